pec_streamer_sink_pack: RTL and testbench

// Parametrised output sink for the PEC accelerator: captures NCH result channels per output

---
 rtl/pec_streamer_sink_pack_if.sv | 42 ++++
 rtl/pec_streamer_sink_pack.sv | 257 +++++++++++++++++++++++++
 tb/tb_pec_streamer_sink_pack.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pec_streamer_sink_pack_if.sv
// Handshake bundle between the PEC controller/datapath and the output sink:
// job configuration, element capture, TCDM transfer request and packed stream.
interface pec_streamer_sink_pack_if #(
  parameter int NCH   = 16,
  parameter int DW    = 16,
  parameter int BW    = 32,
  parameter int CNT_W = 16
);
  logic              clear;
  logic              start;
  logic [31:0]       cfg_base;
  logic [7:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_row_len;
  logic [CNT_W-1:0]  cfg_total;
  logic [31:0]       cfg_stride;
  logic              cfg_mode;
  logic              pix_valid;
  logic              pix_ready;
  logic [NCH*DW-1:0] pix;
  logic              req_ready;
  logic              req_start;
  logic [31:0]       req_addr;
  logic [15:0]       req_words;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_data;
  logic [BW/8-1:0]   out_strb;
  logic              busy;
  logic              done;

  modport master (
    output clear, start, cfg_base, cfg_ch, cfg_row_len, cfg_total, cfg_stride, cfg_mode,
    output pix_valid, pix, req_ready, out_ready,
    input  pix_ready, req_start, req_addr, req_words, out_valid, out_data, out_strb, busy, done
  );

  modport slave (
    input  clear, start, cfg_base, cfg_ch, cfg_row_len, cfg_total, cfg_stride, cfg_mode,
    input  pix_valid, pix, req_ready, out_ready,
    output pix_ready, req_start, req_addr, req_words, out_valid, out_data, out_strb, busy, done
  );
endinterface

// File: rtl/pec_streamer_sink_pack.sv
// PEC output sink: captures NCH-channel result elements into an NBUF-slot ring and
// streams each one as BW-bit packed words behind a per-element TCDM transfer request.
module pec_streamer_sink_pack #(
  parameter int NCH   = 16,
  parameter int DW    = 16,
  parameter int BW    = 32,
  parameter int NBUF  = 2,
  parameter int CNT_W = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  pec_streamer_sink_pack_if.slave bus
);

  localparam int L16 = BW / 16;
  localparam int L8  = BW / 8;
  localparam int WB  = BW / 8;
  localparam int PW  = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam logic signed [DW-1:0] SAT_HI = DW'(127);
  localparam logic signed [DW-1:0] SAT_LO = DW'(-128);

  typedef enum logic {J_IDLE, J_RUN} job_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STREAM} st_e;

  job_e              job_q;
  st_e               st_q;
  logic [31:0]       stride_q, row_base_q, col_off_q, elem_bytes_q;
  logic [CNT_W-1:0]  row_len_q, total_q, col_q, captured_q, stored_q;
  logic              mode_q;
  logic [15:0]       ch_q, words_q, k_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [NBUF-1:0]   full_q;
  logic [NCH*DW-1:0] buf_q [NBUF];

  logic [31:0]       req_addr_q;
  logic [15:0]       req_words_q;
  logic              out_valid_q, done_q;
  logic [BW-1:0]     out_data_q;
  logic [WB-1:0]     out_strb_q;

  function automatic logic signed [7:0] sat8(input logic signed [DW-1:0] v);
    if (v > SAT_HI) return 8'sh7F;
    if (v < SAT_LO) return -8'sd128;
    return 8'(v);
  endfunction

  function automatic logic signed [15:0] lane16(input logic signed [DW-1:0] v);
    return 16'(v);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(NBUF - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Effective channel count and words per element, evaluated on the start cycle
  logic [15:0] start_ch, start_words;
  always_comb begin
    start_ch = 16'(bus.cfg_ch);
    if (bus.cfg_ch == 8'd0)
      start_ch = 16'd1;
    else if (int'(bus.cfg_ch) > NCH)
      start_ch = 16'(NCH);
    if (bus.cfg_mode)
      start_words = 16'((int'(start_ch) + L8 - 1) / L8);
    else
      start_words = 16'((int'(start_ch) + L16 - 1) / L16);
  end

  logic pix_ready, pix_acc, last_acc;
  assign pix_ready = (job_q == J_RUN) && !full_q[wr_ptr_q] && (captured_q < total_q);
  assign pix_acc   = bus.pix_valid && pix_ready;
  assign last_acc  = (st_q == S_STREAM) && out_valid_q && bus.out_ready &&
                     (k_q == words_q - 16'd1);
  assign rd_nxt    = ptr_inc(rd_ptr_q);

  // Word about to be loaded into the output register: word 0 on request, else k+1
  logic [15:0]       pk;
  logic [NCH*DW-1:0] rd_slot;
  logic [BW-1:0]     pk_data;
  logic [WB-1:0]     pk_strb;
  always_comb begin
    pk      = (st_q == S_STREAM) ? k_q + 16'd1 : 16'd0;
    rd_slot = buf_q[rd_ptr_q];
    pk_data = '0;
    pk_strb = '0;
    if (mode_q) begin
      for (int j = 0; j < L8; j++) begin
        if (int'(pk) * L8 + j < int'(ch_q)) begin
          pk_data[j*8 +: 8] = sat8(rd_slot[(int'(pk) * L8 + j) * DW +: DW]);
          pk_strb[j]        = 1'b1;
        end
      end
    end else begin
      for (int j = 0; j < L16; j++) begin
        if (int'(pk) * L16 + j < int'(ch_q)) begin
          pk_data[j*16 +: 16] = lane16(rd_slot[(int'(pk) * L16 + j) * DW +: DW]);
          pk_strb[j*2 +: 2]   = 2'b11;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pix_acc) buf_q[wr_ptr_q] <= bus.pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_q        <= J_IDLE;
      st_q         <= S_IDLE;
      stride_q     <= '0;
      row_base_q   <= '0;
      col_off_q    <= '0;
      elem_bytes_q <= '0;
      row_len_q    <= '0;
      total_q      <= '0;
      col_q        <= '0;
      captured_q   <= '0;
      stored_q     <= '0;
      mode_q       <= 1'b0;
      ch_q         <= '0;
      words_q      <= '0;
      k_q          <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      full_q       <= '0;
      req_addr_q   <= '0;
      req_words_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      done_q       <= 1'b0;
    end else if (bus.clear) begin
      job_q        <= J_IDLE;
      st_q         <= S_IDLE;
      stride_q     <= '0;
      row_base_q   <= '0;
      col_off_q    <= '0;
      elem_bytes_q <= '0;
      row_len_q    <= '0;
      total_q      <= '0;
      col_q        <= '0;
      captured_q   <= '0;
      stored_q     <= '0;
      mode_q       <= 1'b0;
      ch_q         <= '0;
      words_q      <= '0;
      k_q          <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      full_q       <= '0;
      req_addr_q   <= '0;
      req_words_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Job control: an empty job completes without ever entering RUN
      case (job_q)
        J_IDLE: begin
          if (bus.start) begin
            stride_q     <= bus.cfg_stride;
            row_base_q   <= bus.cfg_base;
            col_off_q    <= '0;
            col_q        <= '0;
            elem_bytes_q <= 32'(start_words) * 32'(WB);
            row_len_q    <= (bus.cfg_row_len == '0) ? CNT_W'(1) : bus.cfg_row_len;
            total_q      <= bus.cfg_total;
            mode_q       <= bus.cfg_mode;
            ch_q         <= start_ch;
            words_q      <= start_words;
            captured_q   <= '0;
            stored_q     <= '0;
            if (bus.cfg_total == '0) done_q <= 1'b1;
            else                     job_q  <= J_RUN;
          end
        end
        default: begin
          if (last_acc && (stored_q + CNT_W'(1) == total_q)) begin
            job_q  <= J_IDLE;
            done_q <= 1'b1;
          end
        end
      endcase

      if (pix_acc) begin
        full_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        captured_q       <= captured_q + CNT_W'(1);
      end

      // Store side: request, then stream the slot; address counters step per request
      case (st_q)
        S_IDLE: begin
          if (full_q[rd_ptr_q]) begin
            st_q        <= S_REQ;
            req_addr_q  <= row_base_q + col_off_q;
            req_words_q <= words_q;
          end
        end
        S_REQ: begin
          if (bus.req_ready) begin
            st_q        <= S_STREAM;
            k_q         <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= pk_data;
            out_strb_q  <= pk_strb;
            if (col_q + CNT_W'(1) >= row_len_q) begin
              col_q      <= '0;
              col_off_q  <= '0;
              row_base_q <= row_base_q + stride_q;
            end else begin
              col_q     <= col_q + CNT_W'(1);
              col_off_q <= col_off_q + elem_bytes_q;
            end
          end
        end
        default: begin
          if (out_valid_q && bus.out_ready) begin
            if (last_acc) begin
              full_q[rd_ptr_q] <= 1'b0;
              rd_ptr_q         <= rd_nxt;
              stored_q         <= stored_q + CNT_W'(1);
              out_valid_q      <= 1'b0;
              if ((NBUF > 1) && full_q[rd_nxt]) begin
                st_q        <= S_REQ;
                req_addr_q  <= row_base_q + col_off_q;
                req_words_q <= words_q;
              end else begin
                st_q <= S_IDLE;
              end
            end else begin
              k_q        <= k_q + 16'd1;
              out_data_q <= pk_data;
              out_strb_q <= pk_strb;
            end
          end
        end
      endcase
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.req_start = (st_q == S_REQ) && bus.req_ready;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_words = req_words_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_strb  = out_strb_q;
  assign bus.busy      = (job_q == J_RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pec_streamer_sink_pack.sv
// Directed bench for pec_streamer_sink_pack: 16-bit and saturating 8-bit packing,
// addressing, ring back-pressure, clear mid-stream, empty and overlapping starts.
module tb_pec_streamer_sink_pack;
  localparam int NCH = 16, DW = 16, BW = 32, NBUF = 2, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pec_streamer_sink_pack_if #(.NCH(NCH), .DW(DW), .BW(BW), .CNT_W(CNT_W)) bus ();

  pec_streamer_sink_pack #(.NCH(NCH), .DW(DW), .BW(BW), .NBUF(NBUF), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] data_q[$];
  logic [3:0]  strb_q[$];
  logic [31:0] addr_q[$];
  logic [15:0] rw_q[$];
  int done_cnt = 0, cur_w = 8, wcnt = 0, acc_cnt = 0, stored_cnt = 0, viol = 0, seen2 = 0;
  bit   rnd_mode = 1'b0;
  logic ready_man = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] vpat(input int p, input int c);
    return 16'(4096 + p * 256 + c);
  endfunction

  function automatic logic [NCH*DW-1:0] pat_pix(input int p);
    logic [NCH*DW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*16 +: 16] = vpat(p, c);
    return r;
  endfunction

  // Observer: accepted words, transfer requests, done pulses and ring occupancy
  always @(negedge clk) begin
    int occ;
    occ = acc_cnt - stored_cnt;
    if (occ >= NBUF && bus.pix_ready) viol++;
    if (occ == NBUF && bus.pix_valid) seen2++;
    if (bus.pix_valid && bus.pix_ready) acc_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      data_q.push_back(bus.out_data);
      strb_q.push_back(bus.out_strb);
      wcnt++;
      if (wcnt >= cur_w) begin
        wcnt = 0;
        stored_cnt++;
      end
    end
    if (bus.req_start) begin
      addr_q.push_back(bus.req_addr);
      rw_q.push_back(bus.req_words);
    end
    if (bus.done) done_cnt++;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_man;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] base, input logic [7:0] ch, input logic [15:0] rl,
                           input logic [15:0] tot, input logic [31:0] stride, input logic mode);
    bus.cfg_base = base;  bus.cfg_ch = ch;         bus.cfg_row_len = rl;
    bus.cfg_total = tot;  bus.cfg_stride = stride; bus.cfg_mode = mode;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_pix(input logic [NCH*DW-1:0] d);
    int n;
    n = 0;
    bus.pix_valid = 1'b1;
    bus.pix = d;
    forever begin
      @(negedge clk);
      if (bus.pix_ready) break;
      n++;
      if (n > 1000) begin
        chk("pix_timeout", 0, 1);
        break;
      end
    end
    tick();
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_busy_end"}, bus.busy, 0);
    tick();
  endtask

  initial begin
    int d0, a0, w0, v0, s0, n;
    logic [31:0] exp_addr[6];
    logic [NCH*DW-1:0] px;

    bus.clear = 0; bus.start = 0; bus.cfg_base = 0; bus.cfg_ch = 0; bus.cfg_row_len = 0;
    bus.cfg_total = 0; bus.cfg_stride = 0; bus.cfg_mode = 0; bus.pix_valid = 0;
    bus.pix = '0; bus.req_ready = 1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_req_start", bus.req_start, 0);
    chk("rst_req_addr", bus.req_addr, 0);
    rst_n = 1'b1;
    tick();

    // 16-bit lanes, 2x2 tensor
    d0 = done_cnt; a0 = addr_q.size(); w0 = data_q.size(); cur_w = 8;
    start_job(32'h1000, 8'd16, 16'd2, 16'd4, 32'h100, 1'b0);
    chk("t1_busy", bus.busy, 1);
    for (int p = 0; p < 4; p++) send_pix(pat_pix(p));
    wait_done(d0, "t1");
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1020; exp_addr[2] = 32'h1100; exp_addr[3] = 32'h1120;
    chk("t1_nreq", addr_q.size() - a0, 4);
    if (addr_q.size() - a0 == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", addr_q[a0+i], exp_addr[i]);
        chk("t1_req_words", rw_q[a0+i], 8);
      end
    chk("t1_nwords", data_q.size() - w0, 32);
    if (data_q.size() - w0 == 32)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < 8; k++) begin
          chk("t1_word", data_q[w0+p*8+k], {vpat(p, 2*k+1), vpat(p, 2*k)});
          chk("t1_strb", strb_q[w0+p*8+k], 4'hF);
        end
    repeat (5) tick();
    chk("t1_done_once", done_cnt - d0, 1);

    // 15 channels: last word half empty; request-to-first-word latency
    d0 = done_cnt; a0 = addr_q.size(); w0 = data_q.size(); cur_w = 8;
    start_job(32'h2000, 8'd15, 16'd1, 16'd1, 32'h10, 1'b0);
    send_pix(pat_pix(10));
    n = 0;
    while (!bus.req_start && n < 100) begin @(negedge clk); n++; end
    chk("t2_req_seen", bus.req_start, 1);
    chk("t2_req_addr", bus.req_addr, 32'h2000);
    tick();
    chk("t2_first_valid", bus.out_valid, 1);
    chk("t2_first_data", bus.out_data, 32'h1A01_1A00);
    wait_done(d0, "t2");
    chk("t2_nwords", data_q.size() - w0, 8);
    if (data_q.size() - w0 == 8) begin
      chk("t2_last_data", data_q[w0+7], 32'h0000_1A0E);
      chk("t2_last_strb", strb_q[w0+7], 4'b0011);
      chk("t2_w6_strb", strb_q[w0+6], 4'hF);
    end
    chk("t2_req_words", rw_q[a0], 8);

    // 8-bit saturating lanes
    d0 = done_cnt; a0 = addr_q.size(); w0 = data_q.size(); cur_w = 4;
    px = '0;
    px[0*16 +: 16] = 16'd300;   px[1*16 +: 16] = 16'hFED4; px[2*16 +: 16] = 16'd5;
    px[3*16 +: 16] = 16'hFFFF;  px[4*16 +: 16] = 16'd127;  px[5*16 +: 16] = 16'd128;
    px[6*16 +: 16] = 16'hFF80;  px[7*16 +: 16] = 16'hFF7F;
    start_job(32'h3000, 8'd16, 16'd4, 16'd2, 32'h1000, 1'b1);
    send_pix(px);
    send_pix(px);
    wait_done(d0, "t3");
    chk("t3_nreq", addr_q.size() - a0, 2);
    if (addr_q.size() - a0 == 2) begin
      chk("t3_addr0", addr_q[a0], 32'h3000);
      chk("t3_addr1", addr_q[a0+1], 32'h3010);
      chk("t3_req_words", rw_q[a0], 4);
    end
    chk("t3_nwords", data_q.size() - w0, 8);
    if (data_q.size() - w0 == 8)
      for (int e = 0; e < 2; e++) begin
        chk("t3_w0", data_q[w0+e*4],   32'hFF05_807F);
        chk("t3_w1", data_q[w0+e*4+1], 32'h8080_7F7F);
        chk("t3_w2", data_q[w0+e*4+2], 32'h0);
        chk("t3_strb", strb_q[w0+e*4+3], 4'hF);
      end

    // Random stream back-pressure with continuous element supply
    d0 = done_cnt; a0 = addr_q.size(); w0 = data_q.size(); cur_w = 2;
    v0 = viol; s0 = seen2;
    rnd_mode = 1'b1;
    start_job(32'h4000, 8'd4, 16'd3, 16'd6, 32'h40, 1'b0);
    for (int p = 0; p < 6; p++) send_pix(pat_pix(20 + p));
    wait_done(d0, "t4");
    rnd_mode = 1'b0;
    exp_addr[0] = 32'h4000; exp_addr[1] = 32'h4008; exp_addr[2] = 32'h4010;
    exp_addr[3] = 32'h4040; exp_addr[4] = 32'h4048; exp_addr[5] = 32'h4050;
    chk("t4_nreq", addr_q.size() - a0, 6);
    if (addr_q.size() - a0 == 6)
      for (int i = 0; i < 6; i++) chk("t4_addr", addr_q[a0+i], exp_addr[i]);
    chk("t4_nwords", data_q.size() - w0, 12);
    if (data_q.size() - w0 == 12)
      for (int p = 0; p < 6; p++) begin
        chk("t4_word0", data_q[w0+p*2],   {vpat(20+p, 1), vpat(20+p, 0)});
        chk("t4_word1", data_q[w0+p*2+1], {vpat(20+p, 3), vpat(20+p, 2)});
      end
    chk("t4_ready_when_full", viol - v0, 0);
    chk("t4_full_reached", (seen2 > s0), 1);

    // Clear while streaming word 3
    d0 = done_cnt; w0 = data_q.size(); cur_w = 8;
    start_job(32'h5000, 8'd16, 16'd1, 16'd2, 32'h0, 1'b0);
    send_pix(pat_pix(30));
    n = 0;
    while (data_q.size() - w0 < 3 && n < 200) begin tick(); n++; end
    chk("t5_reached_w3", data_q.size() - w0, 3);
    bus.clear = 1'b1;
    ready_man = 1'b0;
    tick();
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_out_data", bus.out_data, 0);
    chk("t5_out_strb", bus.out_strb, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_pix_ready", bus.pix_ready, 0);
    bus.clear = 1'b0;
    ready_man = 1'b1;
    repeat (20) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_no_more_words", data_q.size() - w0, 3);
    d0 = done_cnt; a0 = addr_q.size(); w0 = data_q.size(); wcnt = 0;
    start_job(32'h5800, 8'd16, 16'd1, 16'd1, 32'h0, 1'b0);
    send_pix(pat_pix(31));
    wait_done(d0, "t5b");
    chk("t5b_addr", addr_q[a0], 32'h5800);
    chk("t5b_nwords", data_q.size() - w0, 8);
    if (data_q.size() - w0 == 8) begin
      chk("t5b_first", data_q[w0], {vpat(31, 1), vpat(31, 0)});
      chk("t5b_last", data_q[w0+7], {vpat(31, 15), vpat(31, 14)});
    end

    // Empty job, then a start pulse during a running job
    d0 = done_cnt; a0 = addr_q.size();
    start_job(32'h6000, 8'd16, 16'd1, 16'd0, 32'h80, 1'b0);
    chk("t6_done_pulse", bus.done, 1);
    chk("t6_busy", bus.busy, 0);
    tick();
    chk("t6_done_low", bus.done, 0);
    repeat (4) tick();
    chk("t6_no_req", addr_q.size() - a0, 0);
    chk("t6_done_once", done_cnt - d0, 1);

    d0 = done_cnt; a0 = addr_q.size(); cur_w = 8;
    start_job(32'h6000, 8'd16, 16'd0, 16'd2, 32'h80, 1'b0);
    chk("t6b_busy", bus.busy, 1);
    start_job(32'h7000, 8'd16, 16'd1, 16'd1, 32'h0, 1'b0);
    send_pix(pat_pix(40));
    send_pix(pat_pix(41));
    wait_done(d0, "t6b");
    repeat (4) tick();
    chk("t6b_done_once", done_cnt - d0, 1);
    chk("t6b_nreq", addr_q.size() - a0, 2);
    if (addr_q.size() - a0 == 2) begin
      chk("t6b_addr0", addr_q[a0], 32'h6000);
      chk("t6b_addr1", addr_q[a0+1], 32'h6080);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
